// File: rtl/cram_port_arbiter_if.sv
// Bundle of the requester-side and OPB-side signals of the CRAM port arbiter.
// The master modport is the arbiter's view; slave is the requesters plus controller.
interface cram_port_arbiter_if #(
    parameter int NPORT = 3
);
    logic [NPORT-1:0]    p_req;
    logic [NPORT*24-1:0] p_addr;
    logic [NPORT*4-1:0]  p_be;
    logic [NPORT*32-1:0] p_wdata;
    logic [NPORT-1:0]    p_rnw;
    logic [NPORT-1:0]    p_32bit;
    logic [NPORT-1:0]    p_ack;
    logic                p_err;
    logic [31:0]         p_rdata;
    logic [2:0]          grant_id;
    logic                busy;
    logic [23:0]         OPB_ABus;
    logic [3:0]          OPB_BE;
    logic [31:0]         OPB_DBus;
    logic                OPB_RNW;
    logic                OPB_32Bit;
    logic                OPB_select;
    logic [31:0]         Sln_DBus;
    logic                Sln_xferAck;

    modport master (
        input  p_req, p_addr, p_be, p_wdata, p_rnw, p_32bit, Sln_DBus, Sln_xferAck,
        output p_ack, p_err, p_rdata, grant_id, busy,
               OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_32Bit, OPB_select
    );

    modport slave (
        output p_req, p_addr, p_be, p_wdata, p_rnw, p_32bit, Sln_DBus, Sln_xferAck,
        input  p_ack, p_err, p_rdata, grant_id, busy,
               OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_32Bit, OPB_select
    );
endinterface

// File: rtl/cram_port_arbiter.sv
// Round-robin arbiter sharing one OPB-style CRAM/PSRAM controller port between
// NPORT requesters, with a watchdog that aborts transactions the controller never finishes.
module cram_port_arbiter #(
    parameter int NPORT      = 3,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 1
) (
    input logic                 OPB_Clk,
    input logic                 OPB_Rst,
    cram_port_arbiter_if.master bus
);
    localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(CMAX + 1);
    localparam logic [TW-1:0]    TIMEOUT_T  = TW'(TIMEOUT);
    localparam logic [TW-1:0]    GAP_LAST_T = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [2:0]       LAST_PORT  = 3'(NPORT - 1);
    localparam logic [NPORT-1:0] ACK_ONE    = NPORT'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t           state_r;
    logic [2:0]       rr_ptr_r;
    logic [TW-1:0]    timer_r;
    logic [NPORT-1:0] p_ack_r;
    logic             p_err_r;
    logic [31:0]      p_rdata_r;
    logic [2:0]       grant_id_r;
    logic             busy_r;
    logic [23:0]      opb_abus_r;
    logic [3:0]       opb_be_r;
    logic [31:0]      opb_dbus_r;
    logic             opb_rnw_r;
    logic             opb_32bit_r;
    logic             opb_select_r;

    logic [3:0]       pick_s;
    logic [2:0]       win_s;
    logic [23:0]      addr_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic             rnw_s;
    logic             b32_s;

    // Returns {found, index} of the first requester after ptr, wrapping;
    // scanning from the far end lets the nearest candidate win.
    function automatic logic [3:0] rr_pick(input logic [NPORT-1:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [7:0] req8;
        logic [2:0] idx;
        res  = 4'd0;
        req8 = 8'(req);
        for (int i = NPORT; i >= 1; i--) begin
            idx = 3'((int'(ptr) + i) % NPORT);
            res = req8[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Winner selection and its request fields
    always_comb begin
        pick_s  = rr_pick(bus.p_req, rr_ptr_r);
        win_s   = pick_s[2:0];
        addr_s  = 24'h0;
        be_s    = 4'h0;
        wdata_s = 32'h0;
        rnw_s   = 1'b0;
        b32_s   = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            addr_s  = (win_s == 3'(i)) ? bus.p_addr[i*24 +: 24]  : addr_s;
            be_s    = (win_s == 3'(i)) ? bus.p_be[i*4 +: 4]      : be_s;
            wdata_s = (win_s == 3'(i)) ? bus.p_wdata[i*32 +: 32] : wdata_s;
            rnw_s   = (win_s == 3'(i)) ? bus.p_rnw[i]            : rnw_s;
            b32_s   = (win_s == 3'(i)) ? bus.p_32bit[i]          : b32_s;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= LAST_PORT;
            timer_r      <= '0;
            p_ack_r      <= '0;
            p_err_r      <= 1'b0;
            p_rdata_r    <= 32'h0;
            grant_id_r   <= 3'd0;
            busy_r       <= 1'b0;
            opb_abus_r   <= 24'h0;
            opb_be_r     <= 4'h0;
            opb_dbus_r   <= 32'h0;
            opb_rnw_r    <= 1'b0;
            opb_32bit_r  <= 1'b0;
            opb_select_r <= 1'b0;
        end else begin
            p_ack_r <= '0;
            p_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_s[3]) begin
                        opb_abus_r  <= addr_s;
                        opb_be_r    <= be_s;
                        opb_dbus_r  <= wdata_s;
                        opb_rnw_r   <= rnw_s;
                        opb_32bit_r <= b32_s;
                        grant_id_r  <= win_s;
                        rr_ptr_r    <= win_s;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        opb_select_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    opb_select_r <= 1'b1;
                    busy_r       <= 1'b1;
                    timer_r      <= '0;
                    state_r      <= WAIT_LOW;
                end
                // A high ack here is left over from the previous access; only a drop counts.
                WAIT_LOW: begin
                    if (timer_r == TIMEOUT_T) begin
                        p_ack_r <= ACK_ONE << grant_id_r;
                        p_err_r <= 1'b1;
                        state_r <= DONE;
                    end else if (!bus.Sln_xferAck) begin
                        timer_r <= timer_r + TIMER_ONE;
                        state_r <= WAIT_HIGH;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (bus.Sln_xferAck) begin
                        p_rdata_r <= bus.Sln_DBus;
                        p_ack_r   <= ACK_ONE << grant_id_r;
                        state_r   <= DONE;
                    end else if (timer_r == TIMEOUT_T) begin
                        p_ack_r <= ACK_ONE << grant_id_r;
                        p_err_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                DONE: begin
                    opb_select_r <= 1'b0;
                    timer_r      <= '0;
                    state_r      <= GAP;
                end
                GAP: begin
                    if (timer_r == GAP_LAST_T) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    opb_select_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.p_ack      = p_ack_r;
    assign bus.p_err      = p_err_r;
    assign bus.p_rdata    = p_rdata_r;
    assign bus.grant_id   = grant_id_r;
    assign bus.busy       = busy_r;
    assign bus.OPB_ABus   = opb_abus_r;
    assign bus.OPB_BE     = opb_be_r;
    assign bus.OPB_DBus   = opb_dbus_r;
    assign bus.OPB_RNW    = opb_rnw_r;
    assign bus.OPB_32Bit  = opb_32bit_r;
    assign bus.OPB_select = opb_select_r;
endmodule

// File: tb/tb_cram_port_arbiter.sv
// Directed bench for cram_port_arbiter: a small OPB controller model answers each
// select, and expected completions queued at request time are checked on p_ack.
module tb_cram_port_arbiter;
    localparam int NPORT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cram_port_arbiter_if #(.NPORT(NPORT)) bus ();

    cram_port_arbiter #(.NPORT(NPORT), .TIMEOUT(255), .GAP_CYCLES(1)) dut (
        .OPB_Clk (clk),
        .OPB_Rst (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  port;
        logic [23:0] addr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Controller model: ack drops low_dly cycles after a select rise, returns high_dly later
    logic        hang     = 1'b0;
    int          low_dly  = 2;
    int          high_dly = 6;
    logic [31:0] rd_data  = 32'h0;
    logic        sel_q;
    int          ph;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.Sln_xferAck <= 1'b1;
            bus.Sln_DBus    <= 32'h0;
            sel_q           <= 1'b0;
            ph              <= 0;
        end else begin
            sel_q <= bus.OPB_select;
            if (!bus.OPB_select) begin
                ph <= 0;
            end else if (!sel_q) begin
                ph <= 1;
            end else if (ph != 0) begin
                ph <= ph + 1;
                if (!hang && ph == low_dly) bus.Sln_xferAck <= 1'b0;
                if (!hang && ph == low_dly + high_dly) begin
                    bus.Sln_xferAck <= 1'b1;
                    bus.Sln_DBus    <= rd_data;
                    ph              <= 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int i, input logic [23:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic rnw, input logic b32);
        bus.p_addr[i*24 +: 24]  = addr;
        bus.p_be[i*4 +: 4]      = be;
        bus.p_wdata[i*32 +: 32] = wdata;
        bus.p_rnw[i]            = rnw;
        bus.p_32bit[i]          = b32;
    endtask

    task automatic push(input logic [2:0] port, input logic [23:0] addr,
                        input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.addr  = addr;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic check_ack();
        exp_t e;
        logic [2:0] one;
        logic [2:0] exp_ack;
        one = 3'b001;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(bus.p_ack), 64'(0));
        end else begin
            e       = sb.pop_front();
            exp_ack = one << e.port;
            chk("ack_port", bus.p_ack, exp_ack);
            chk("grant_id", bus.grant_id, e.port);
            chk("p_err", bus.p_err, e.err);
            chk("p_rdata", bus.p_rdata, e.rdata);
            chk("opb_abus", bus.OPB_ABus, e.addr);
        end
    endtask

    task automatic post_check();
        @(negedge clk);
        chk("ack_pulse", bus.p_ack, 3'b000);
        chk("gap_select", bus.OPB_select, 1'b0);
    endtask

    task automatic wait_and_check(input int budget);
        logic found;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            found = (bus.p_ack != 3'b000);
        end
        chk("ack_seen", found, 1'b1);
        if (found) begin
            check_ack();
            post_check();
        end else begin
            void'(sb.pop_front());
        end
    endtask

    task automatic wait_select(input int budget);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = bus.OPB_select;
        end
        chk("select_seen", seen, 1'b1);
    endtask

    initial begin
        int   hits;
        int   bad;
        int   cnt;
        logic found;

        bus.p_req   = '0;
        bus.p_addr  = '0;
        bus.p_be    = '0;
        bus.p_wdata = '0;
        bus.p_rnw   = '0;
        bus.p_32bit = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_select", bus.OPB_select, 1'b0);
        chk("rst_p_ack", bus.p_ack, 3'b000);
        chk("rst_p_err", bus.p_err, 1'b0);
        chk("rst_p_rdata", bus.p_rdata, 32'h0);
        chk("rst_grant_id", bus.grant_id, 3'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_abus", bus.OPB_ABus, 24'h0);
        chk("rst_dbus", bus.OPB_DBus, 32'h0);
        chk("rst_be", bus.OPB_BE, 4'h0);
        chk("rst_rnw", bus.OPB_RNW, 1'b0);
        chk("rst_32bit", bus.OPB_32Bit, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin from reset: 0,1,2,0,1,2
        set_port(0, 24'h000010, 4'hF, 32'h0, 1'b1, 1'b0);
        set_port(1, 24'h000020, 4'hF, 32'h0, 1'b1, 1'b0);
        set_port(2, 24'h000030, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'hA5A5_0000;
        for (int k = 0; k < 6; k++) push(3'(k % 3), 24'h000010 + 24'(16 * (k % 3)), 32'hA5A5_0000, 1'b0);
        bus.p_req = 3'b111;
        for (int k = 0; k < 6; k++) wait_and_check(100);
        bus.p_req = 3'b000;
        chk("rr_sb_drained", sb.size(), 0);

        // Single read from port 1 with latency check
        @(negedge clk);
        set_port(1, 24'h000100, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'hBEEF_BEEF;
        push(3'd1, 24'h000100, 32'hBEEF_BEEF, 1'b0);
        bus.p_req = 3'b010;
        @(posedge clk);
        @(negedge clk);
        chk("lat_n1_select", bus.OPB_select, 1'b0);
        chk("lat_n1_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk("lat_n2_select", bus.OPB_select, 1'b1);
        chk("rd_rnw", bus.OPB_RNW, 1'b1);
        wait_and_check(100);
        bus.p_req = 3'b000;

        // Stale ack: no completion until the ack has gone low and high again
        @(negedge clk);
        low_dly = 20;
        set_port(0, 24'h000200, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'h5555_AAAA;
        push(3'd0, 24'h000200, 32'h5555_AAAA, 1'b0);
        bus.p_req = 3'b001;
        hits = 0;
        repeat (18) begin
            @(negedge clk);
            if (bus.p_ack != 3'b000) hits++;
        end
        chk("stale_no_ack", hits, 0);
        chk("stale_select", bus.OPB_select, 1'b1);
        wait_and_check(100);
        bus.p_req = 3'b000;
        low_dly = 2;

        // 32-bit write on port 2; bus must stay frozen even if the port changes its inputs
        @(negedge clk);
        set_port(2, 24'h800010, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
        rd_data = 32'h0BAD_F00D;
        push(3'd2, 24'h800010, 32'h0BAD_F00D, 1'b0);
        bus.p_req = 3'b100;
        wait_select(10);
        set_port(2, 24'h7FFFFF, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        bad   = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.OPB_ABus !== 24'h800010 || bus.OPB_DBus !== 32'h1234_5678 ||
                bus.OPB_BE !== 4'hF || bus.OPB_RNW !== 1'b0 || bus.OPB_32Bit !== 1'b1) bad++;
            @(negedge clk);
            found = (bus.p_ack != 3'b000);
        end
        chk("wr32_ack_seen", found, 1'b1);
        chk("wr32_stable", bad, 0);
        chk("wr32_rnw", bus.OPB_RNW, 1'b0);
        chk("wr32_32bit", bus.OPB_32Bit, 1'b1);
        chk("wr32_dbus", bus.OPB_DBus, 32'h1234_5678);
        if (found) begin
            check_ack();
            post_check();
        end
        bus.p_req = 3'b000;

        // Watchdog: controller never accepts
        @(negedge clk);
        hang = 1'b1;
        set_port(1, 24'h000300, 4'hF, 32'h0, 1'b1, 1'b0);
        push(3'd1, 24'h000300, 32'h0BAD_F00D, 1'b1);
        bus.p_req = 3'b010;
        wait_select(10);
        cnt   = 0;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            cnt++;
            found = (bus.p_ack != 3'b000);
        end
        chk("timeout_latency", cnt, 256);
        if (found) begin
            check_ack();
            post_check();
        end
        bus.p_req = 3'b000;
        hang = 1'b0;

        // Healthy transaction after the abort
        @(negedge clk);
        set_port(0, 24'h000400, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'hCAFE_0001;
        push(3'd0, 24'h000400, 32'hCAFE_0001, 1'b0);
        bus.p_req = 3'b001;
        wait_and_check(100);
        bus.p_req = 3'b000;

        // Reset while waiting for completion
        @(negedge clk);
        set_port(2, 24'h000500, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'hDEAD_0000;
        bus.p_req = 3'b100;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            found = bus.OPB_select && !bus.Sln_xferAck;
        end
        chk("mid_accept_seen", found, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_select", bus.OPB_select, 1'b0);
        chk("mid_rst_p_ack", bus.p_ack, 3'b000);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_grant", bus.grant_id, 3'd0);
        chk("mid_rst_abus", bus.OPB_ABus, 24'h0);
        chk("mid_rst_rdata", bus.p_rdata, 32'h0);
        chk("mid_rst_err", bus.p_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_port(1, 24'h000600, 4'hF, 32'h0, 1'b1, 1'b0);
        rd_data = 32'h1111_2222;
        push(3'd1, 24'h000600, 32'h1111_2222, 1'b0);
        push(3'd2, 24'h000500, 32'h1111_2222, 1'b0);
        bus.p_req = 3'b110;
        rst_n     = 1'b1;
        wait_and_check(100);
        bus.p_req = 3'b100;
        wait_and_check(100);
        bus.p_req = 3'b000;
        chk("final_sb_drained", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
